// File: rtl/pc_gen_bp.sv
// Fetch-address generator: PC register, next-PC priority mux and a direct-mapped
// BTB with 2-bit saturating counters, trained from the D-stage branch resolution.
module pc_gen_bp #(
  parameter logic [31:0] RESET_PC  = 32'hBFC00000,
  parameter logic [31:0] EXC_VEC   = 32'hBFC00380,
  parameter int unsigned BTB_IDX_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        IntReq,
  input  logic        eret,
  input  logic [31:0] EPC,
  input  logic        res_valid,
  input  logic [31:0] res_pc,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  input  logic        res_pred_taken,
  input  logic [31:0] res_pred_target,
  output logic [31:0] PC,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic        mispredict
);

  localparam int unsigned BTB_DEPTH = 1 << BTB_IDX_W;
  localparam int unsigned TAG_W     = 30 - BTB_IDX_W;

  logic [31:0]          r_pc;
  logic                 r_valid  [BTB_DEPTH];
  logic [1:0]           r_ctr    [BTB_DEPTH];
  logic [TAG_W-1:0]     r_tag    [BTB_DEPTH];
  logic [31:0]          r_target [BTB_DEPTH];

  logic [BTB_IDX_W-1:0] w_look_idx;
  logic [TAG_W-1:0]     w_look_tag;
  logic                 w_look_hit;
  logic [BTB_IDX_W-1:0] w_res_idx;
  logic [TAG_W-1:0]     w_res_tag;
  logic                 w_res_hit;
  logic [31:0]          w_redirect;
  logic [31:0]          w_next_pc;

  // Combinational lookup on the current fetch address
  assign w_look_idx  = r_pc[BTB_IDX_W+1:2];
  assign w_look_tag  = r_pc[31:BTB_IDX_W+2];
  assign w_look_hit  = r_valid[w_look_idx] && (r_tag[w_look_idx] == w_look_tag);
  assign pred_taken  = w_look_hit && r_ctr[w_look_idx][1];
  assign pred_target = pred_taken ? r_target[w_look_idx] : 32'd0;

  assign w_res_idx = res_pc[BTB_IDX_W+1:2];
  assign w_res_tag = res_pc[31:BTB_IDX_W+2];
  assign w_res_hit = r_valid[w_res_idx] && (r_tag[w_res_idx] == w_res_tag);

  assign mispredict = res_valid &&
                      ((res_taken != res_pred_taken) ||
                       (res_taken && (res_target != res_pred_target)));
  assign w_redirect = res_taken ? res_target : (res_pc + 32'd4);

  // Exception entry and eret outrank the redirect; the redirect outranks stall
  always_comb begin
    w_next_pc = r_pc + 32'd4;
    if (IntReq) begin
      w_next_pc = EXC_VEC;
    end else if (eret) begin
      w_next_pc = EPC;
    end else if (mispredict) begin
      w_next_pc = w_redirect;
    end else if (stall) begin
      w_next_pc = r_pc;
    end else if (pred_taken) begin
      w_next_pc = pred_target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  // Valid bits and counters; training is independent of the PC selection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < BTB_DEPTH; i++) begin
        r_valid[BTB_IDX_W'(i)] <= 1'b0;
        r_ctr[BTB_IDX_W'(i)]   <= 2'b00;
      end
    end else if (res_valid) begin
      if (w_res_hit) begin
        if (res_taken) begin
          r_ctr[w_res_idx] <= (r_ctr[w_res_idx] == 2'b11) ? 2'b11 : (r_ctr[w_res_idx] + 2'd1);
        end else begin
          r_ctr[w_res_idx] <= (r_ctr[w_res_idx] == 2'b00) ? 2'b00 : (r_ctr[w_res_idx] - 2'd1);
        end
      end else if (res_taken) begin
        r_valid[w_res_idx] <= 1'b1;
        r_ctr[w_res_idx]   <= 2'b10;
      end
    end
  end

  // Tag/target payload needs no reset: it is only observed behind a valid bit
  always_ff @(posedge clk) begin
    if (!reset && res_valid && res_taken) begin
      r_target[w_res_idx] <= res_target;
      if (!w_res_hit) begin
        r_tag[w_res_idx] <= w_res_tag;
      end
    end
  end

  assign PC = r_pc;

endmodule

// File: tb/tb_pc_gen_bp.sv
// Directed self-checking bench for pc_gen_bp: reset, training, counters,
// next-PC priority, aliasing and asynchronous reset.
module tb_pc_gen_bp;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        IntReq;
  logic        eret;
  logic [31:0] EPC;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_taken;
  logic [31:0] res_target;
  logic        res_pred_taken;
  logic [31:0] res_pred_target;
  logic [31:0] PC;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        mispredict;

  int errors = 0;
  int checks = 0;

  pc_gen_bp #(
    .RESET_PC (32'hBFC00000),
    .EXC_VEC  (32'hBFC00380),
    .BTB_IDX_W(4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .IntReq         (IntReq),
    .eret           (eret),
    .EPC            (EPC),
    .res_valid      (res_valid),
    .res_pc         (res_pc),
    .res_taken      (res_taken),
    .res_target     (res_target),
    .res_pred_taken (res_pred_taken),
    .res_pred_target(res_pred_target),
    .PC             (PC),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .mispredict     (mispredict)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; IntReq = 0; eret = 0; EPC = 0;
    res_valid = 0; res_pc = 0; res_taken = 0; res_target = 0;
    res_pred_taken = 0; res_pred_target = 0;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt);
    res_valid = 1; res_pc = pc; res_taken = tk; res_target = tgt;
    res_pred_taken = ptk; res_pred_target = ptgt;
  endtask

  // Load PC through the eret path, which leaves the BTB untouched
  task automatic jump_to(input logic [31:0] addr);
    clear_inputs();
    eret = 1; EPC = addr;
    step();
    clear_inputs();
    #2;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    #3;
    checks++; if (PC !== 32'hBFC00000) begin errors++; $display("FAIL reset_pc: got %h expected %h", PC, 32'hBFC00000); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred_taken: got %b expected 0", pred_taken); end
    checks++; if (pred_target !== 32'd0) begin errors++; $display("FAIL reset_pred_target: got %h expected 0", pred_target); end
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL reset_mispredict: got %b expected 0", mispredict); end
    @(negedge clk);
    reset = 0;
    #1;
    checks++; if (PC !== 32'hBFC00000) begin errors++; $display("FAIL release_pc: got %h expected %h", PC, 32'hBFC00000); end
    step();
    checks++; if (PC !== 32'hBFC00004) begin errors++; $display("FAIL seq_pc1: got %h expected %h", PC, 32'hBFC00004); end
    step();
    checks++; if (PC !== 32'hBFC00008) begin errors++; $display("FAIL seq_pc2: got %h expected %h", PC, 32'hBFC00008); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL seq_pred_taken: got %b expected 0", pred_taken); end
  endtask

  task automatic test_train();
    resolve(32'hBFC00010, 1, 32'hBFC00100, 0, 32'd0);
    #2;
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL train_mispredict: got %b expected 1", mispredict); end
    step();
    clear_inputs();
    checks++; if (PC !== 32'hBFC00100) begin errors++; $display("FAIL train_redirect: got %h expected %h", PC, 32'hBFC00100); end
    jump_to(32'hBFC00010);
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL train_pred_taken: got %b expected 1", pred_taken); end
    checks++; if (pred_target !== 32'hBFC00100) begin errors++; $display("FAIL train_pred_target: got %h expected %h", pred_target, 32'hBFC00100); end
    step();
    checks++; if (PC !== 32'hBFC00100) begin errors++; $display("FAIL train_follow: got %h expected %h", PC, 32'hBFC00100); end
  endtask

  task automatic test_counter();
    // Entry starts at 10; three taken resolutions saturate it at 11
    for (int k = 0; k < 3; k++) begin
      resolve(32'hBFC00010, 1, 32'hBFC00100, 1, 32'hBFC00100);
      #2;
      checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL ctr_taken_mispredict%0d: got %b expected 0", k, mispredict); end
      step();
    end
    resolve(32'hBFC00010, 0, 32'd0, 0, 32'd0);
    step();
    jump_to(32'hBFC00010);
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL ctr_after_nt1: got %b expected 1", pred_taken); end
    resolve(32'hBFC00010, 0, 32'd0, 1, 32'hBFC00100);
    #2;
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL ctr_nt_mispredict: got %b expected 1", mispredict); end
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL ctr_no_bypass: got %b expected 1", pred_taken); end
    step();
    clear_inputs();
    checks++; if (PC !== 32'hBFC00014) begin errors++; $display("FAIL ctr_nt_redirect: got %h expected %h", PC, 32'hBFC00014); end
    jump_to(32'hBFC00010);
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL ctr_after_nt2: got %b expected 0", pred_taken); end
    checks++; if (pred_target !== 32'd0) begin errors++; $display("FAIL ctr_target_zero: got %h expected 0", pred_target); end
    step();
    checks++; if (PC !== 32'hBFC00014) begin errors++; $display("FAIL ctr_seq: got %h expected %h", PC, 32'hBFC00014); end
  endtask

  task automatic test_priority();
    IntReq = 1; eret = 1; EPC = 32'h00400020; stall = 1;
    resolve(32'h00400100, 1, 32'h00400200, 0, 32'd0);
    #2;
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL prio_mispredict: got %b expected 1", mispredict); end
    step();
    clear_inputs();
    checks++; if (PC !== 32'hBFC00380) begin errors++; $display("FAIL prio_exc: got %h expected %h", PC, 32'hBFC00380); end
    jump_to(32'h00400020);
    checks++; if (PC !== 32'h00400020) begin errors++; $display("FAIL prio_eret: got %h expected %h", PC, 32'h00400020); end
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (PC !== 32'h00400020) begin errors++; $display("FAIL stall_hold%0d: got %h expected %h", k, PC, 32'h00400020); end
    end
    resolve(32'h00400040, 0, 32'd0, 1, 32'h00400080);
    step();
    clear_inputs();
    checks++; if (PC !== 32'h00400044) begin errors++; $display("FAIL stall_vs_redirect: got %h expected %h", PC, 32'h00400044); end
    resolve(32'hFFFFFFFC, 0, 32'd0, 1, 32'h00001000);
    step();
    clear_inputs();
    checks++; if (PC !== 32'h00000000) begin errors++; $display("FAIL redirect_wrap: got %h expected 0", PC); end
    resolve(32'h00400100, 1, 32'h00400300, 1, 32'h00400200);
    #2;
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL target_mispredict: got %b expected 1", mispredict); end
    step();
    clear_inputs();
    checks++; if (PC !== 32'h00400300) begin errors++; $display("FAIL target_redirect: got %h expected %h", PC, 32'h00400300); end
    jump_to(32'h00400100);
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL train_under_intreq: got %b expected 1", pred_taken); end
    checks++; if (pred_target !== 32'h00400300) begin errors++; $display("FAIL target_update: got %h expected %h", pred_target, 32'h00400300); end
    jump_to(32'hFFFFFFFC);
    step();
    checks++; if (PC !== 32'h00000000) begin errors++; $display("FAIL pc_wrap: got %h expected 0", PC); end
  endtask

  task automatic test_alias();
    resolve(32'h00400010, 1, 32'h00400080, 0, 32'd0);
    step();
    jump_to(32'h00400010);
    checks++; if (pred_target !== 32'h00400080) begin errors++; $display("FAIL alias_first: got %h expected %h", pred_target, 32'h00400080); end
    stall = 1;
    resolve(32'h00400410, 1, 32'h00400800, 1, 32'h00400800);
    #2;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL alias_same_cycle: got %b expected 1", pred_taken); end
    step();
    clear_inputs();
    #2;
    checks++; if (PC !== 32'h00400010) begin errors++; $display("FAIL alias_hold: got %h expected %h", PC, 32'h00400010); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL alias_evicted: got %b expected 0", pred_taken); end
    jump_to(32'h00400410);
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL alias_second_taken: got %b expected 1", pred_taken); end
    checks++; if (pred_target !== 32'h00400800) begin errors++; $display("FAIL alias_second_target: got %h expected %h", pred_target, 32'h00400800); end
  endtask

  task automatic test_async_reset();
    resolve(32'h00400020, 1, 32'h00400900, 0, 32'd0);
    #1;
    reset = 1;
    #1;
    checks++; if (PC !== 32'hBFC00000) begin errors++; $display("FAIL async_reset_pc: got %h expected %h", PC, 32'hBFC00000); end
    clear_inputs();
    @(negedge clk);
    reset = 0;
    #1;
    checks++; if (PC !== 32'hBFC00000) begin errors++; $display("FAIL async_release_pc: got %h expected %h", PC, 32'hBFC00000); end
    jump_to(32'h00400410);
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL async_btb_cleared: got %b expected 0", pred_taken); end
    jump_to(32'h00400020);
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL async_pending_dropped: got %b expected 0", pred_taken); end
  endtask

  initial begin
    test_reset();
    test_train();
    test_counter();
    test_priority();
    test_alias();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_gen_bp.md
# pc_gen_bp

Parametrised fetch-address generator for the MIPS pipeline. It combines the PC register, next-PC selection and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. It predicts taken branches at IF, takes the branch resolution from D, redirects fetch and raises a flush on a mispredict, and keeps the exception entry and `eret` paths at top priority. It replaces the combinational next-PC mux plus external PC register in IF.

## Interface
- `RESET_PC`, 32'hBFC00000: PC value loaded on reset.
- `EXC_VEC`, 32'hBFC00380: exception/interrupt entry address.
- `BTB_IDX_W`, 4: index width; the BTB has 2^BTB_IDX_W entries; legal range 1..10.
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `stall` in 1: hold PC (IF/D freeze).
- `IntReq` in 1: take interrupt/exception.
- `eret` in 1: return from exception.
- `EPC` in 32: `eret` target.
- `res_valid` in 1: D-stage branch/jump resolution is valid this cycle. The sender already qualifies it with the D-stage valid and not-stalled conditions.
- `res_pc` in 32: PC of the resolved instruction.
- `res_taken` in 1: actual direction.
- `res_target` in 32: actual taken target.
- `res_pred_taken` in 1: prediction carried down with the instruction.
- `res_pred_target` in 32: predicted target carried down.
- `PC` out 32: current fetch address (register).
- `pred_taken` out 1: BTB predicts `PC` is a taken branch.
- `pred_target` out 32: predicted target (0 when `pred_taken`=0).
- `mispredict` out 1: flush the IF instruction and redirect.

## Operation
- BTB entry contents: `valid`, `tag` = addr[31:BTB_IDX_W+2], `target`[31:0], `ctr`[1:0]. Index = addr[BTB_IDX_W+1:2]. Address bits [1:0] are ignored.
- Lookup is combinational on `PC`.
  - hit = valid && tag match.
  - `pred_taken` = hit && ctr[1].
  - `pred_target` = entry target when `pred_taken`, else 0.
- `mispredict` = `res_valid` && (`res_taken` != `res_pred_taken` || (`res_taken` && `res_target` != `res_pred_target`)).
- Redirect address:
  - `res_target` when `res_taken`.
  - `res_pc`+4 otherwise; the adder wraps modulo 2^32.
- Next PC priority, highest first:
  1. `IntReq` → EXC_VEC.
  2. `eret` → EPC.
  3. `mispredict` → redirect address.
  4. `stall` → PC (hold).
  5. `pred_taken` → `pred_target`.
  6. Otherwise PC+4, wrapping modulo 2^32.
- BTB update happens on `res_valid`, indexed by `res_pc`.
  - Hit, taken: ctr saturating increment (max 2'b11); target ← `res_target`.
  - Hit, not taken: ctr saturating decrement (min 2'b00); target unchanged.
  - Miss, taken: allocate and overwrite. valid=1, tag from `res_pc`, target=`res_target`, ctr=2'b10.
  - Miss, not taken: no change.
- The BTB update is independent of `IntReq`/`eret`/`stall`. A valid resolution always trains the BTB.
- There is no separate jump class. Jumps are trained as always-taken branches, and `jr` is trained with its register target.

## Timing
- Reset (async, immediate):
  - PC=RESET_PC.
  - All BTB valid=0 and ctr=2'b00; tag/target values are don't-care.
  - Outputs settle to `pred_taken`=0, `pred_target`=0, `mispredict`=0 when `res_valid`=0.
- Reset asserted mid-operation discards any pending update. The first fetch after release is RESET_PC.
- PC latency: the next-PC selection made in cycle n is visible on `PC` in cycle n+1.
- Prediction has 0-cycle latency (same cycle as `PC`).
- `mispredict` is combinational in the cycle `res_valid` is high. The surrounding pipeline flushes the instruction fetched that cycle.
- BTB write takes effect at the edge that ends the resolving cycle.
  - A same-cycle lookup of the same index sees the old contents; there is no bypass.
  - The lookup one cycle later sees the new contents.
- Simultaneous `IntReq`+`mispredict`: PC ← EXC_VEC, `mispredict` still asserts, and the BTB still trains.
- Simultaneous `stall`+`mispredict`: the redirect wins.
- Aliasing: different PCs sharing an index evict each other; a tag mismatch is a miss.

## Test plan
- Reset with `res_valid`=0 → `PC`=0xBFC00000, then 0xBFC00004, 0xBFC00008 on successive edges; `pred_taken`=0 throughout.
- Train branch at 0xBFC00010: `res_valid`=1, `res_pc`=0xBFC00010, `res_taken`=1, `res_target`=0xBFC00100, predicted 0.
  - Same cycle: `mispredict`=1, and the next `PC`=0xBFC00100.
  - Next time PC=0xBFC00010: `pred_taken`=1, `pred_target`=0xBFC00100, and the next PC=0xBFC00100.
- Counter saturation:
  - Three taken resolutions → ctr=11.
  - One not-taken → ctr=10, still predicts taken.
  - A second not-taken → ctr=01, `pred_taken`=0.
  - Resolution not-taken with `res_pred_taken`=1 → `mispredict`=1, PC ← `res_pc`+4.
- Priority: `IntReq`=1, `eret`=1, `stall`=1 and a mispredict together → PC=0xBFC00380. Then `eret`=1 with EPC=0x00400020 → PC=0x00400020. `stall` alone → PC holds for 3 cycles.
- Aliasing with BTB_IDX_W=4: train 0x00400010 taken. Then train 0x00400410 taken to 0x00400800 → lookup of 0x00400010 misses (`pred_taken`=0), and 0x00400410 predicts 0x00400800.
- Async reset pulse between edges after training → `PC`=0xBFC00000 immediately, and the previously trained PC no longer predicts.
